pipe_skid_reg: RTL
==================

// Module: pipe_skid_reg
// PURPOSE
//  Registered valid/ready pipeline stage built on enable-gated D flops. Feeds downstream
//  flop-based datapath stages and decouples their stall (out_ready) from the upstream source.
//  Two-entry skid buffer: full throughput (1 beat/cycle), registered in_ready, no comb path
//  from out_ready to in_ready. Standard inter-stage register for the core pipeline.
// PARAMETERS
//  WIDTH   32   payload width in bits (>=1)
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      upstream beat present
//  in_ready   out  1      stage accepts a beat this cycle (registered)
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      downstream beat present (registered)
//  out_ready  in   1      downstream accepts this cycle
//  out_data   out  WIDTH  downstream payload (registered, main reg)
//  count      out  2      occupancy 0..2 (debug/perf)
// BEHAVIOUR
//  - Reset: async assert on rst_n low, no clock needed. state=EMPTY, out_valid=0, in_ready=0,
//    count=0, main/skid regs=0. First posedge after rst_n high: in_ready=1.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - States (2-bit): EMPTY(count 0), BUSY(count 1, main valid), FULL(count 2, main+skid valid).
//  - EMPTY: in_fire -> BUSY, main<=in_data. Else hold.
//  - BUSY: in_fire & out_fire -> BUSY, main<=in_data.
//          in_fire & !out_fire -> FULL, skid<=in_data, main held.
//          !in_fire & out_fire -> EMPTY.  Neither -> hold.
//  - FULL: out_fire -> BUSY, main<=skid. Else hold. in_fire impossible (in_ready=0).
//  - in_ready next = (next_state != FULL); out_valid next = (next_state != EMPTY);
//    count next = encoded next_state. All registered; no comb input-to-output path.
//  - Latency: beat accepted at edge N visible on out_data/out_valid after edge N (1 cycle).
//  - Stability: while out_valid & !out_ready, out_data and out_valid must not change.
//  - Order preserved; no beat dropped or duplicated under any valid/ready pattern.
//  - in_data ignored when !in_fire; main/skid only load on the listed transitions.
//  - in_valid may drop without a transfer (no upstream hold requirement assumed by stage).
//  - Reset mid-operation: buffered beats discarded, outputs per reset values immediately.
// TESTING
//  1 Reset: rst_n=0 at t=23ns mid-BUSY -> out_valid=0,in_ready=0,count=0 before next edge;
//    release -> in_ready=1 after first posedge.
//  2 Stream: out_ready=1, in 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 one cycle
//    later, in_ready stays 1, count=1 throughout.
//  3 Backpressure: out_ready=0, send 0xA1,0xA2 -> count=2, in_ready=0 after 2nd accept,
//    out_data=0xA1 stable; source holds 0xA3 until in_ready=1.
//  4 Drain: from case 3 set out_ready=1 -> outputs 0xA1,0xA2,0xA3 in order, count 2->1->1->0.
//  5 Simultaneous in/out in BUSY (count=1, both fire) -> count stays 1, out_data = new beat.
//  6 Random in_valid/out_ready (50%/30%), 1000 beats, WIDTH=8 and 32 -> scoreboard exact match,
//    stability check on stalled output, no beat accepted while in_ready=0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid-buffer valid/ready stage with registered in_ready, out_valid and out_data
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] skid;
  logic in_fire, out_fire;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // the state encoding doubles as the occupancy count
  always_comb begin
    nxt = state == EMPTY ? (in_fire ? BUSY : EMPTY) :
          state == BUSY  ? ((in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : BUSY) :
                           (out_fire ? BUSY : FULL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      count     <= 2'd0;
      out_data  <= '0;
      skid      <= '0;
    end else begin
      state     <= nxt;
      in_ready  <= nxt != FULL;
      out_valid <= nxt != EMPTY;
      count     <= nxt;
      if (in_fire && (state == EMPTY || out_fire)) out_data <= in_data;
      else if (state == FULL && out_fire) out_data <= skid;
      if (in_fire && state == BUSY && !out_fire) skid <= in_data;
    end
  end
endmodule
